// File: rtl/naive_bus_pkg.sv
// Shared naive_bus constants and a helper for sizing master-index fields.
package naive_bus_pkg;

  localparam int BE_W   = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  // A single-master index still needs one bit to stay a legal vector.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/naive_bus_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first set request scanning ptr, ptr+1, ... modulo N.
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // One spare bit so ptr+k cannot overflow before the modulo wrap.
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!valid && req[cand[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/naive_bus_rr_arbiter.sv
// Round-robin arbiter sharing one naive_bus slave among N_MASTER masters,
// one transaction per cycle, read data steered back one cycle after grant.
module naive_bus_rr_arbiter
  import naive_bus_pkg::*;
#(
  parameter int N_MASTER = 3,
  parameter int IDX_W    = idx_width(N_MASTER)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_MASTER-1:0]        m_rd_req,
  input  logic [BE_W*N_MASTER-1:0]   m_rd_be,
  input  logic [ADDR_W*N_MASTER-1:0] m_rd_addr,
  output logic [N_MASTER-1:0]        m_rd_gnt,
  output logic [DATA_W*N_MASTER-1:0] m_rd_data,
  input  logic [N_MASTER-1:0]        m_wr_req,
  input  logic [BE_W*N_MASTER-1:0]   m_wr_be,
  input  logic [ADDR_W*N_MASTER-1:0] m_wr_addr,
  input  logic [DATA_W*N_MASTER-1:0] m_wr_data,
  output logic [N_MASTER-1:0]        m_wr_gnt,
  output logic                       s_rd_req,
  output logic [BE_W-1:0]            s_rd_be,
  output logic [ADDR_W-1:0]          s_rd_addr,
  input  logic                       s_rd_gnt,
  input  logic [DATA_W-1:0]          s_rd_data,
  output logic                       s_wr_req,
  output logic [BE_W-1:0]            s_wr_be,
  output logic [ADDR_W-1:0]          s_wr_addr,
  output logic [DATA_W-1:0]          s_wr_data,
  input  logic                       s_wr_gnt
);

  logic [IDX_W-1:0]  ptr;
  logic              rtag_v;
  logic [IDX_W-1:0]  rtag_idx;

  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic              w_rd, w_wr;
  logic [BE_W-1:0]   w_rd_be, w_wr_be;
  logic [ADDR_W-1:0] w_rd_addr, w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic              rd_fire, wr_fire;

  rr_pick #(
    .N     (N_MASTER),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (m_rd_req | m_wr_req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    w_rd      = 1'b0;
    w_wr      = 1'b0;
    w_rd_be   = '0;
    w_wr_be   = '0;
    w_rd_addr = '0;
    w_wr_addr = '0;
    w_wr_data = '0;
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        w_rd      = m_rd_req[i];
        w_wr      = m_wr_req[i];
        w_rd_be   = m_rd_be[i*BE_W +: BE_W];
        w_wr_be   = m_wr_be[i*BE_W +: BE_W];
        w_rd_addr = m_rd_addr[i*ADDR_W +: ADDR_W];
        w_wr_addr = m_wr_addr[i*ADDR_W +: ADDR_W];
        w_wr_data = m_wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A winner with both requests forwards only its read this cycle.
  assign s_rd_req  = pick_valid & w_rd;
  assign s_wr_req  = pick_valid & ~w_rd & w_wr;
  assign s_rd_be   = pick_valid ? w_rd_be   : '0;
  assign s_rd_addr = pick_valid ? w_rd_addr : '0;
  assign s_wr_be   = pick_valid ? w_wr_be   : '0;
  assign s_wr_addr = pick_valid ? w_wr_addr : '0;
  assign s_wr_data = pick_valid ? w_wr_data : '0;

  assign rd_fire = s_rd_req & s_rd_gnt;
  assign wr_fire = s_wr_req & s_wr_gnt;

  always_comb begin
    m_rd_gnt  = '0;
    m_wr_gnt  = '0;
    m_rd_data = '0;
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      m_rd_gnt[i] = rd_fire && (pick_idx == IDX_W'(i));
      m_wr_gnt[i] = wr_fire && (pick_idx == IDX_W'(i));
      if (rtag_v && (rtag_idx == IDX_W'(i)))
        m_rd_data[i*DATA_W +: DATA_W] = s_rd_data;
    end
  end

  // Pointer moves only on a grant, so a stalled winner keeps the slave.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      rtag_v   <= 1'b0;
      rtag_idx <= '0;
    end else begin
      if (rd_fire || wr_fire)
        ptr <= (pick_idx == IDX_W'(N_MASTER-1)) ? '0 : pick_idx + 1'b1;
      rtag_v   <= rd_fire;
      rtag_idx <= pick_idx;
    end
  end

endmodule

// File: tb/tb_naive_bus_rr_arbiter.sv
// Randomized and directed checks of naive_bus_rr_arbiter against a behavioural model.
module tb_naive_bus_rr_arbiter;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  m_rd_req, m_wr_req, m_rd_gnt, m_wr_gnt;
  logic [4*N-1:0]  m_rd_be, m_wr_be;
  logic [32*N-1:0] m_rd_addr, m_wr_addr, m_wr_data, m_rd_data;
  logic          s_rd_req, s_wr_req, s_rd_gnt, s_wr_gnt;
  logic [3:0]    s_rd_be, s_wr_be;
  logic [31:0]   s_rd_addr, s_wr_addr, s_wr_data, s_rd_data;

  int tests = 0;
  int fails = 0;

  // model state
  int mp = 0;
  bit mtv = 1'b0;
  int mtidx = 0;
  // per-cycle model results
  bit e_v, e_srd, e_swr, e_rdg, e_wrg;
  int e_win;

  naive_bus_rr_arbiter #(.N_MASTER(N)) dut (
    .clk(clk), .rst(rst),
    .m_rd_req(m_rd_req), .m_rd_be(m_rd_be), .m_rd_addr(m_rd_addr),
    .m_rd_gnt(m_rd_gnt), .m_rd_data(m_rd_data),
    .m_wr_req(m_wr_req), .m_wr_be(m_wr_be), .m_wr_addr(m_wr_addr),
    .m_wr_data(m_wr_data), .m_wr_gnt(m_wr_gnt),
    .s_rd_req(s_rd_req), .s_rd_be(s_rd_be), .s_rd_addr(s_rd_addr),
    .s_rd_gnt(s_rd_gnt), .s_rd_data(s_rd_data),
    .s_wr_req(s_wr_req), .s_wr_be(s_wr_be), .s_wr_addr(s_wr_addr),
    .s_wr_data(s_wr_data), .s_wr_gnt(s_wr_gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    m_rd_req = '0; m_wr_req = '0;
    m_rd_be = '0; m_wr_be = '0;
    m_rd_addr = '0; m_wr_addr = '0; m_wr_data = '0;
    s_rd_gnt = 1'b0; s_wr_gnt = 1'b0; s_rd_data = '0;
  endtask

  // Evaluate the model for the current inputs and compare every output.
  task automatic drive_check();
    logic [N-1:0]    eg_r, eg_w;
    logic [32*N-1:0] ed;
    if (rst) begin mp = 0; mtv = 1'b0; mtidx = 0; end
    #1;
    e_v = 1'b0; e_win = 0;
    for (int j = 0; j < N; j++) begin
      int k;
      k = (mp + j) % N;
      if (!e_v && (m_rd_req[k] || m_wr_req[k])) begin e_v = 1'b1; e_win = k; end
    end
    e_srd = e_v && m_rd_req[e_win];
    e_swr = e_v && !m_rd_req[e_win] && m_wr_req[e_win];
    e_rdg = e_srd && s_rd_gnt;
    e_wrg = e_swr && s_wr_gnt;
    eg_r = '0; eg_w = '0;
    if (e_rdg) eg_r[e_win] = 1'b1;
    if (e_wrg) eg_w[e_win] = 1'b1;
    ed = '0;
    if (mtv) ed[mtidx*32 +: 32] = s_rd_data;
    chk("m_rd_gnt", 96'(m_rd_gnt), 96'(eg_r));
    chk("m_wr_gnt", 96'(m_wr_gnt), 96'(eg_w));
    chk("s_rd_req", 96'(s_rd_req), 96'(e_srd));
    chk("s_wr_req", 96'(s_wr_req), 96'(e_swr));
    chk("m_rd_data", 96'(m_rd_data), 96'(ed));
    if (e_srd) begin
      chk("s_rd_addr", 96'(s_rd_addr), 96'(m_rd_addr[e_win*32 +: 32]));
      chk("s_rd_be", 96'(s_rd_be), 96'(m_rd_be[e_win*4 +: 4]));
    end
    if (e_swr) begin
      chk("s_wr_addr", 96'(s_wr_addr), 96'(m_wr_addr[e_win*32 +: 32]));
      chk("s_wr_be", 96'(s_wr_be), 96'(m_wr_be[e_win*4 +: 4]));
      chk("s_wr_data", 96'(s_wr_data), 96'(m_wr_data[e_win*32 +: 32]));
    end
    if (!e_v)
      chk("idle_fields", {s_rd_addr, s_wr_addr, s_wr_data},
          {{s_rd_be, s_wr_be} == 8'h0 ? 32'h0 : 32'hFFFF_FFFF, 64'h0});
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      mp = 0; mtv = 1'b0; mtidx = 0;
    end else begin
      if (e_rdg || e_wrg) mp = (e_win + 1) % N;
      mtv = e_rdg;
      mtidx = e_win;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle(); rst = 1'b1;
    drive_check();
    advance();
    @(negedge clk);
    rst = 1'b0;
    drive_check();
    advance();
  endtask

  initial begin
    logic [2:0] order [6];
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100;
    order[3] = 3'b001; order[4] = 3'b010; order[5] = 3'b100;

    set_idle();
    rst = 1'b1;
    drive_check();
    chk("reset_rd_gnt", 96'(m_rd_gnt), 96'h0);
    chk("reset_wr_gnt", 96'(m_wr_gnt), 96'h0);
    chk("reset_rd_data", 96'(m_rd_data), 96'h0);
    advance();
    @(negedge clk); rst = 1'b0; drive_check(); advance();

    // single master read
    @(negedge clk);
    set_idle();
    m_rd_req = 3'b010; m_rd_addr[32 +: 32] = 32'h100; m_rd_be[4 +: 4] = 4'hF; s_rd_gnt = 1'b1;
    drive_check();
    chk("single_gnt", 96'(m_rd_gnt), 96'(3'b010));
    chk("single_addr", 96'(s_rd_addr), 96'h100);
    advance();
    @(negedge clk);
    set_idle(); s_rd_data = 32'hDEAD_BEEF;
    drive_check();
    chk("single_data", 96'(m_rd_data), {32'h0, 32'hDEAD_BEEF, 32'h0});
    advance();

    // contention, grant order 0,1,2,0,1,2
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      set_idle(); m_rd_req = 3'b111; s_rd_gnt = 1'b1; s_rd_data = $urandom;
      drive_check();
      chk("rr_order", 96'(m_rd_gnt), 96'(order[c]));
      advance();
    end

    // stall: move ptr to 2, then master 2 writes while master 0 reads
    do_reset();
    @(negedge clk);
    set_idle(); m_rd_req = 3'b010; s_rd_gnt = 1'b1;
    drive_check(); advance();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      set_idle();
      m_rd_req = 3'b001; m_wr_req = 3'b100;
      m_wr_addr[64 +: 32] = 32'h0000_0A00; m_wr_data[64 +: 32] = 32'h5555_AAAA; m_wr_be[8 +: 4] = 4'hC;
      s_rd_gnt = 1'b1; s_wr_gnt = (c == 3);
      drive_check();
      chk("stall_s_wr_addr", 96'(s_wr_addr), 96'h0A00);
      chk("stall_wr_gnt", 96'(m_wr_gnt), (c == 3) ? 96'(3'b100) : 96'h0);
      chk("stall_rd_gnt", 96'(m_rd_gnt), 96'h0);
      advance();
    end
    @(negedge clk);
    set_idle(); m_rd_req = 3'b001; s_rd_gnt = 1'b1;
    drive_check();
    chk("after_stall", 96'(m_rd_gnt), 96'(3'b001));
    advance();

    // read + write on the same master
    do_reset();
    @(negedge clk);
    set_idle();
    m_rd_req = 3'b001; m_wr_req = 3'b001;
    m_wr_data[0 +: 32] = 32'h1234_5678; m_wr_be[0 +: 4] = 4'h3;
    s_rd_gnt = 1'b1; s_wr_gnt = 1'b1;
    drive_check();
    chk("rw_read_first", 96'(m_rd_gnt), 96'(3'b001));
    chk("rw_no_wr_yet", 96'(s_wr_req), 96'h0);
    advance();
    @(negedge clk);
    m_rd_req = 3'b000;
    drive_check();
    chk("rw_wr_gnt", 96'(m_wr_gnt), 96'(3'b001));
    chk("rw_wr_data", 96'(s_wr_data), 96'h1234_5678);
    chk("rw_wr_be", 96'(s_wr_be), 96'h3);
    advance();

    // reset in the cycle after a read grant
    do_reset();
    @(negedge clk);
    set_idle(); m_rd_req = 3'b010; s_rd_gnt = 1'b1;
    drive_check(); advance();
    @(negedge clk);
    set_idle(); rst = 1'b1; s_rd_data = 32'hCAFE_F00D;
    drive_check();
    chk("midrst_data", 96'(m_rd_data), 96'h0);
    advance();
    @(negedge clk);
    rst = 1'b0;
    drive_check();
    chk("midrst_after", 96'(m_rd_data), 96'h0);
    advance();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      m_rd_req = N'($urandom) & N'($urandom);
      m_wr_req = N'($urandom) & N'($urandom);
      m_rd_be = 12'($urandom); m_wr_be = 12'($urandom);
      m_rd_addr = {$urandom, $urandom, $urandom};
      m_wr_addr = {$urandom, $urandom, $urandom};
      m_wr_data = {$urandom, $urandom, $urandom};
      s_rd_gnt = ($urandom_range(0, 3) != 0);
      s_wr_gnt = ($urandom_range(0, 3) != 0);
      s_rd_data = $urandom;
      drive_check();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
